// File: rtl/pc_sequencer_if.sv
// Bus between the program-counter sequencer and its driver: the control
// requests going in and the registered fetch address and status coming out.
interface pc_sequencer_if;
  logic       halt;
  logic       stall;
  logic       fetch_ack;
  logic       ret;
  logic       call;
  logic [7:0] call_target;
  logic       jmp;
  logic [7:0] jmp_target;
  logic       br_take;
  logic [7:0] br_target;
  logic [7:0] pc_out;
  logic       fetch_req;
  logic       ras_err;

  // Driver side: issues control requests, observes the program counter.
  modport master (
    output halt, stall, fetch_ack, ret, call, call_target,
           jmp, jmp_target, br_take, br_target,
    input  pc_out, fetch_req, ras_err
  );

  // Sequencer side.
  modport slave (
    input  halt, stall, fetch_ack, ret, call, call_target,
           jmp, jmp_target, br_take, br_target,
    output pc_out, fetch_req, ras_err
  );
endinterface

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: IDLE/FETCH/STALL/HALT control FSM with
// prioritised next-PC selection (ret > call > jmp > br_take > increment).
// Optional return-address stack is compiled in when PC_SEQ_RAS_EN is defined;
// without it, call acts as a jump, ret as an increment, and ras_err is 0.
module pc_sequencer #(
  parameter logic [7:0] RESET_VEC = 8'h00,
  parameter int         RAS_DEPTH = 4
) (
  input logic          clk,
  input logic          rst_n,
  pc_sequencer_if.slave bus
);

  if (RAS_DEPTH < 2 || RAS_DEPTH > 8) begin : g_depth_chk
    $error("pc_sequencer: RAS_DEPTH must be in 2..8");
  end

  typedef enum logic [1:0] {IDLE, FETCH, STALL, HALT} state_t;

  state_t     state_q, state_d;
  logic [7:0] pc_q, pc_d;
  logic       fetch_req_q;
  logic [7:0] pc_inc;
  logic       accept;

  // Only a FETCH cycle that memory acknowledges, with no hold or halt, moves the PC.
  assign pc_inc = pc_q + 8'd1;
  assign accept = (state_q == FETCH) && bus.fetch_ack && !bus.stall && !bus.halt;

  // Next-state logic; halt dominates everything and is only left through reset.
  always_comb begin
    state_d = state_q;
    if (bus.halt) begin
      state_d = HALT;
    end else begin
      case (state_q)
        IDLE:    state_d = FETCH;
        FETCH:   if (bus.stall) state_d = STALL;
        STALL:   if (!bus.stall) state_d = FETCH;
        HALT:    state_d = HALT;
        default: state_d = IDLE;
      endcase
    end
  end

`ifdef PC_SEQ_RAS_EN
  localparam int CNT_W = $clog2(RAS_DEPTH + 1);
  localparam int IDX_W = $clog2(RAS_DEPTH);
  localparam logic [CNT_W-1:0] FULL = CNT_W'(RAS_DEPTH);

  logic [7:0]       ras_q [2**IDX_W];
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;
  logic             push;
  logic [IDX_W-1:0] wr_idx, rd_idx;

  assign wr_idx = cnt_q[IDX_W-1:0];
  assign rd_idx = IDX_W'(cnt_q - CNT_W'(1));

  // Next PC and stack bookkeeping; a simultaneous call and ret performs only the ret.
  always_comb begin
    pc_d  = pc_q;
    cnt_d = cnt_q;
    err_d = err_q;
    push  = 1'b0;
    if (accept) begin
      if (bus.ret) begin
        if (cnt_q != '0) begin
          pc_d  = ras_q[rd_idx];
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          pc_d  = pc_inc;
          err_d = 1'b1;
        end
      end else if (bus.call) begin
        if (cnt_q != FULL) begin
          push  = 1'b1;
          cnt_d = cnt_q + CNT_W'(1);
        end else begin
          err_d = 1'b1;
        end
        pc_d = bus.call_target;
      end else if (bus.jmp) begin
        pc_d = bus.jmp_target;
      end else if (bus.br_take) begin
        pc_d = bus.br_target;
      end else begin
        pc_d = pc_inc;
      end
    end
  end

  // Stack storage holds data only; validity is tracked by cnt_q.
  always_ff @(posedge clk) begin
    if (push) ras_q[wr_idx] <= pc_inc;
  end

  // Stack depth and sticky error flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  assign bus.ras_err = err_q;
`else
  // Next PC without a stack: call is a plain jump, ret a plain increment.
  always_comb begin
    pc_d = pc_q;
    if (accept) begin
      if (bus.ret)          pc_d = pc_inc;
      else if (bus.call)    pc_d = bus.call_target;
      else if (bus.jmp)     pc_d = bus.jmp_target;
      else if (bus.br_take) pc_d = bus.br_target;
      else                  pc_d = pc_inc;
    end
  end

  assign bus.ras_err = 1'b0;
`endif

  // State, PC and fetch request; fetch_req mirrors "next state is FETCH".
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      pc_q        <= RESET_VEC;
      fetch_req_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      fetch_req_q <= (state_d == FETCH);
    end
  end

  assign bus.pc_out    = pc_q;
  assign bus.fetch_req = fetch_req_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer; expectations follow the build
// configuration (PC_SEQ_RAS_EN selects the stack expectations).
module tb_pc_sequencer;

`ifdef PC_SEQ_RAS_EN
  localparam bit RAS = 1'b1;
`else
  localparam bit RAS = 1'b0;
`endif

  logic clk;
  logic rst_n;
  int   n_chk;
  int   n_err;

  pc_sequencer_if bus ();

  pc_sequencer #(.RESET_VEC(8'h00), .RAS_DEPTH(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic clr();
    bus.ret = 1'b0; bus.call = 1'b0; bus.jmp = 1'b0; bus.br_take = 1'b0;
  endtask

  task automatic do_jmp(input logic [7:0] t);
    bus.jmp = 1'b1; bus.jmp_target = t; tick(); clr();
  endtask

  task automatic do_call(input logic [7:0] t);
    bus.call = 1'b1; bus.call_target = t; tick(); clr();
  endtask

  task automatic do_ret();
    bus.ret = 1'b1; tick(); clr();
  endtask

  logic [7:0] ret_exp [5];
  logic [7:0] call_t  [5];

  initial begin
    n_chk = 0;
    n_err = 0;
    rst_n = 1'b0;
    bus.halt = 1'b0; bus.stall = 1'b0; bus.fetch_ack = 1'b1;
    bus.call_target = 8'h00; bus.jmp_target = 8'h00; bus.br_target = 8'h00;
    clr();

    // Reset state
    #3;
    chk("rst_pc", bus.pc_out, 8'h00);
    chk("rst_freq", bus.fetch_req, 1'b0);
    chk("rst_err", bus.ras_err, 1'b0);
    tick();
    chk("rst_hold_pc", bus.pc_out, 8'h00);
    rst_n = 1'b1;

    // IDLE -> FETCH, then sequential increment
    tick();
    chk("first_freq", bus.fetch_req, 1'b1);
    chk("first_pc", bus.pc_out, 8'h00);
    tick(); chk("inc_01", bus.pc_out, 8'h01);
    tick(); chk("inc_02", bus.pc_out, 8'h02);

    // Wrap FF -> 00
    do_jmp(8'hFE); chk("jmp_fe", bus.pc_out, 8'hFE);
    tick();        chk("inc_ff", bus.pc_out, 8'hFF);
    tick();        chk("wrap_00", bus.pc_out, 8'h00);

    // jmp beats br_take; br_take alone
    do_jmp(8'h10); chk("jmp_10", bus.pc_out, 8'h10);
    bus.jmp = 1'b1; bus.jmp_target = 8'h40; bus.br_take = 1'b1; bus.br_target = 8'h80;
    tick(); clr();
    chk("jmp_over_br", bus.pc_out, 8'h40);
    bus.br_take = 1'b1; bus.br_target = 8'h80; tick(); clr();
    chk("br_80", bus.pc_out, 8'h80);

    // No ack: hold, controls ignored
    bus.fetch_ack = 1'b0; bus.jmp = 1'b1; bus.jmp_target = 8'h77;
    tick(); clr(); bus.fetch_ack = 1'b1;
    chk("noack_pc", bus.pc_out, 8'h80);
    chk("noack_freq", bus.fetch_req, 1'b1);

    // call 30 at 05, increment to 31, ret
    do_jmp(8'h05);
    do_call(8'h30); chk("call_30", bus.pc_out, 8'h30);
    tick();         chk("inc_31", bus.pc_out, 8'h31);
    do_ret();       chk("ret_06", bus.pc_out, RAS ? 8'h06 : 8'h32);
    chk("ret_err0", bus.ras_err, 1'b0);

    // Simultaneous call and ret performs only the ret
    do_call(8'h30);
    bus.call = 1'b1; bus.call_target = 8'h99; bus.ret = 1'b1; tick(); clr();
    chk("call_ret", bus.pc_out, RAS ? 8'h07 : 8'h31);

    // Five nested calls into a four-deep stack
    call_t = '{8'h10, 8'h20, 8'h30, 8'h40, 8'h50};
    if (RAS) ret_exp = '{8'h31, 8'h21, 8'h11, 8'h08, 8'h09};
    else     ret_exp = '{8'h51, 8'h52, 8'h53, 8'h54, 8'h55};
    for (int i = 0; i < 4; i++) begin
      do_call(call_t[i]);
      chk($sformatf("ncall%0d", i), bus.pc_out, call_t[i]);
    end
    chk("err_after4", bus.ras_err, 1'b0);
    do_call(call_t[4]);
    chk("ncall4", bus.pc_out, 8'h50);
    chk("err_after5", bus.ras_err, RAS ? 1'b1 : 1'b0);
    for (int i = 0; i < 5; i++) begin
      do_ret();
      chk($sformatf("nret%0d", i), bus.pc_out, ret_exp[i]);
    end
    chk("err_sticky", bus.ras_err, RAS ? 1'b1 : 1'b0);

    // Stall for three cycles at 20, controls ignored
    do_jmp(8'h20);
    bus.stall = 1'b1; bus.jmp = 1'b1; bus.jmp_target = 8'h66;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("stall_pc%0d", i), bus.pc_out, 8'h20);
      chk($sformatf("stall_freq%0d", i), bus.fetch_req, 1'b0);
    end
    bus.stall = 1'b0; clr();
    tick();
    chk("unstall_freq", bus.fetch_req, 1'b1);
    chk("unstall_pc", bus.pc_out, 8'h20);
    tick(); chk("unstall_inc", bus.pc_out, 8'h21);

    // Halt beats an accept, then stays halted
    do_jmp(8'h55);
    bus.halt = 1'b1; bus.jmp = 1'b1; bus.jmp_target = 8'h77; tick(); clr();
    chk("halt_pc", bus.pc_out, 8'h55);
    chk("halt_freq", bus.fetch_req, 1'b0);
    bus.halt = 1'b0;
    tick(); tick();
    chk("halted_pc", bus.pc_out, 8'h55);
    chk("halted_freq", bus.fetch_req, 1'b0);

    // Asynchronous reset mid-cycle
    #2 rst_n = 1'b0;
    #1;
    chk("arst_pc", bus.pc_out, 8'h00);
    chk("arst_freq", bus.fetch_req, 1'b0);
    chk("arst_err", bus.ras_err, 1'b0);
    #1 rst_n = 1'b1;

    // Reset mid-stall with an entry on the stack
    tick(); chk("re_fetch_pc", bus.pc_out, 8'h00);
    tick(); chk("re_inc_01", bus.pc_out, 8'h01);
    do_call(8'h40);
    bus.stall = 1'b1; tick();
    chk("re_stall_freq", bus.fetch_req, 1'b0);
    #2 rst_n = 1'b0;
    #1 rst_n = 1'b1;
    bus.stall = 1'b0;
    chk("rst_stall_pc", bus.pc_out, 8'h00);
    chk("rst_stall_freq", bus.fetch_req, 1'b0);
    tick();
    chk("post_rst_freq", bus.fetch_req, 1'b1);
    chk("post_rst_pc", bus.pc_out, 8'h00);
    tick(); chk("post_rst_inc", bus.pc_out, 8'h01);
    do_ret();
    chk("empty_ret_pc", bus.pc_out, 8'h02);
    chk("empty_ret_err", bus.ras_err, RAS ? 1'b1 : 1'b0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
